// File: rtl/sysid_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sysid_arb_pkg
//  Purpose  : Shared types and constants for the two-master sysid read arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package sysid_arb_pkg;

    // Data width of the sysid slave (ID word / build timestamp)
    localparam int SYSID_DATA_W = 32;

    // Owner encoding: one bit selects which master holds the grant
    localparam logic OWN_M0 = 1'b0;
    localparam logic OWN_M1 = 1'b1;

    // Grant FSM states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sysid_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : sysid_rr_picker
//  Purpose  : Combinational 2-way winner selection. A single requester wins;
//             on a tie the master not served last wins, or master 0 always
//             wins when SYSID_ARB_FIXED_PRIO_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module sysid_rr_picker
    import sysid_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

`ifdef SYSID_ARB_FIXED_PRIO_EN
    // The history pointer has no meaning with a fixed priority
    logic w_unused_last;
    assign w_unused_last = last;

    // Master 0 wins whenever it requests
    always_comb begin
        winner = OWN_M0;
        if (!req[0] && req[1]) begin
            winner = OWN_M1;
        end
    end
`else
    // Round-robin: on a tie, grant the master that was not served last
    always_comb begin
        winner = OWN_M0;
        case (req)
            2'b01:   winner = OWN_M0;
            2'b10:   winner = OWN_M1;
            2'b11:   winner = ~last;
            default: winner = OWN_M0;
        endcase
    end
`endif

endmodule
`default_nettype wire

// File: rtl/sysid_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sysid_read_arbiter
//  Purpose  : Shares the combinational sysid slave between two Avalon-MM read
//             masters. One read per two cycles: accept in BUSY, return the
//             registered data with a one-cycle readdatavalid strobe.
//             Build option: SYSID_ARB_FIXED_PRIO_EN (master 0 wins ties,
//             no round-robin pointer).
//  Revision : 1.0 - initial release
// ============================================================================
module sysid_read_arbiter
    import sysid_arb_pkg::*;
#(
    parameter int DATA_W = SYSID_DATA_W,
    parameter int ADDR_W = 1
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              m0_read,
    input  logic [ADDR_W-1:0] m0_address,
    output logic              m0_waitrequest,
    output logic              m0_readdatavalid,
    output logic [DATA_W-1:0] m0_readdata,

    input  logic              m1_read,
    input  logic [ADDR_W-1:0] m1_address,
    output logic              m1_waitrequest,
    output logic              m1_readdatavalid,
    output logic [DATA_W-1:0] m1_readdata,

    output logic              s_read,
    output logic [ADDR_W-1:0] s_address,
    input  logic [DATA_W-1:0] s_readdata
);

    state_t            r_state;
    logic              r_owner;
    logic              r_m0_rdv;
    logic              r_m1_rdv;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;

    logic [1:0]        w_req;
    logic              w_winner;
    logic              w_last;
    logic              w_busy;
    logic              w_owner_read;

`ifdef SYSID_ARB_FIXED_PRIO_EN
    assign w_last = OWN_M1;
`else
    logic              r_last;
    assign w_last = r_last;
`endif

    assign w_req = {m1_read, m0_read};

    sysid_rr_picker u_picker (
        .req    (w_req),
        .last   (w_last),
        .winner (w_winner)
    );

    // Slave strobes and waitrequests decode only registered state; the
    // read inputs never reach them combinationally.
    assign w_busy         = (r_state == ST_BUSY);
    assign w_owner_read   = (r_owner == OWN_M1) ? m1_read : m0_read;
    assign s_read         = w_busy;
    assign s_address      = w_busy ? ((r_owner == OWN_M1) ? m1_address : m0_address)
                                   : '0;
    assign m0_waitrequest = !(w_busy && (r_owner == OWN_M0));
    assign m1_waitrequest = !(w_busy && (r_owner == OWN_M1));

    assign m0_readdatavalid = r_m0_rdv;
    assign m1_readdatavalid = r_m1_rdv;
    assign m0_readdata      = r_m0_rdata;
    assign m1_readdata      = r_m1_rdata;

    // Grant FSM: pick in IDLE, accept and capture in BUSY, strobe next cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_owner    <= OWN_M0;
            r_m0_rdv   <= 1'b0;
            r_m1_rdv   <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
`ifndef SYSID_ARB_FIXED_PRIO_EN
            r_last     <= OWN_M1;
`endif
        end else begin
            r_m0_rdv <= 1'b0;
            r_m1_rdv <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_owner <= w_winner;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_state <= ST_IDLE;
                    // A dropped read during BUSY aborts without side effects
                    if (w_owner_read) begin
`ifndef SYSID_ARB_FIXED_PRIO_EN
                        r_last <= r_owner;
`endif
                        if (r_owner == OWN_M1) begin
                            r_m1_rdata <= s_readdata;
                            r_m1_rdv   <= 1'b1;
                        end else begin
                            r_m0_rdata <= s_readdata;
                            r_m0_rdv   <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sysid_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sysid_read_arbiter
//  Purpose  : Self-checking bench for sysid_read_arbiter with a transaction
//             level reference model and per-master scoreboards.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sysid_read_arbiter;

    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [1:0]    rd;
    logic [1:0]    ad;

    logic          m0_waitrequest, m1_waitrequest;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          s_read;
    logic [0:0]    s_address;
    logic [DW-1:0] s_readdata;

    // Sysid slave: word 0 = ID, word 1 = timestamp, combinational
    logic [DW-1:0] mem [2];
    assign s_readdata = mem[s_address];

    sysid_read_arbiter #(.DATA_W(DW), .ADDR_W(1)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .m0_read          (rd[0]),
        .m0_address       (ad[0:0]),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdatavalid (m0_readdatavalid),
        .m0_readdata      (m0_readdata),
        .m1_read          (rd[1]),
        .m1_address       (ad[1:1]),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdatavalid (m1_readdatavalid),
        .m1_readdata      (m1_readdata),
        .s_read           (s_read),
        .s_address        (s_address),
        .s_readdata       (s_readdata)
    );

    always #5 clock = ~clock;

    logic [1:0] wr_v;
    logic [1:0] rdv_v;
    assign wr_v  = {m1_waitrequest, m0_waitrequest};
    assign rdv_v = {m1_readdatavalid, m0_readdatavalid};

    int n_checks;
    int n_errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Arbitration rule: lone requester wins; tie goes to the master not served last
    function automatic int pick(input logic [1:0] req, input int last);
        if (req == 2'b01) return 0;
        if (req == 2'b10) return 1;
`ifdef SYSID_ARB_FIXED_PRIO_EN
        return 0;
`else
        return (last == 0) ? 1 : 0;
`endif
    endfunction

    // Reference model state
    logic          m_busy;
    int            m_last;
    logic [1:0]    pend;
    logic [1:0]    prev_req;
    logic [DW-1:0] held [2];
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];
    int            rdv_cnt [2];
    int            g;
    logic [1:0]    exp_wr;
    logic [DW-1:0] act_rd;

    // Monitor: predicts grants from sampled requests, scores returned data
    always @(negedge clock) begin
        if (!reset_n) begin
            chk("rst_wait", {30'd0, wr_v}, 32'd3);
            chk("rst_rdv", {30'd0, rdv_v}, 32'd0);
            chk("rst_rdata_m0", m0_readdata, 32'd0);
            chk("rst_rdata_m1", m1_readdata, 32'd0);
            chk("rst_s_read", {31'd0, s_read}, 32'd0);
            m_busy   = 1'b0;
            m_last   = 1;
            pend     = 2'b00;
            prev_req = 2'b00;
            held[0]  = '0;
            held[1]  = '0;
            q0.delete();
            q1.delete();
        end else begin
            for (int m = 0; m < 2; m++) begin
                act_rd = (m == 0) ? m0_readdata : m1_readdata;
                chk($sformatf("rdv_timing_m%0d", m), {31'd0, rdv_v[m]}, {31'd0, pend[m]});
                if (rdv_v[m]) begin
                    rdv_cnt[m]++;
                    if (m == 0 && q0.size() > 0) held[0] = q0.pop_front();
                    else if (m == 1 && q1.size() > 0) held[1] = q1.pop_front();
                end
                chk($sformatf("rdata_m%0d", m), act_rd, held[m]);
            end

            g = -1;
            if (!m_busy && prev_req != 2'b00) g = pick(prev_req, m_last);
            exp_wr = {(g != 1), (g != 0)};
            chk("waitrequest", {30'd0, wr_v}, {30'd0, exp_wr});
            chk("s_read", {31'd0, s_read}, {31'd0, (g >= 0)});
            chk("s_address", {31'd0, s_address}, (g >= 0) ? {31'd0, ad[g]} : 32'd0);

            pend = 2'b00;
            if (g >= 0 && rd[g]) begin
                if (g == 0) q0.push_back(mem[ad[0]]);
                else        q1.push_back(mem[ad[1]]);
                pend[g] = 1'b1;
                m_last  = g;
            end
            m_busy   = (g >= 0);
            prev_req = rd;
        end
    end

    // One Avalon read: hold read and address until accepted, then release
    task automatic master_txn(input int m, input logic a);
        int n;
        @(posedge clock); #1;
        rd[m] = 1'b1;
        ad[m] = a;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (wr_v[m] && n < 12);
        chk($sformatf("accept_bound_m%0d", m), {31'd0, wr_v[m]}, 32'd0);
        @(posedge clock); #1;
        rd[m] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock); #1;
        reset_n = 1'b0;
        rd      = 2'b00;
        repeat (2) @(negedge clock);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        int n;
        n_checks   = 0;
        n_errors   = 0;
        rdv_cnt[0] = 0;
        rdv_cnt[1] = 0;
        rd         = 2'b00;
        ad         = 2'b00;
        reset_n    = 1'b0;
        mem[0]     = 32'h0;
        mem[1]     = 32'h56DF_1E71;

        // Reset held, then released with no traffic
        repeat (3) @(negedge clock);
        #1 reset_n = 1'b1;
        idle(3);

        // Single reads by master 0
        master_txn(0, 1'b0);
        master_txn(0, 1'b1);
        idle(2);
        chk("single_m0_data", m0_readdata, 32'h56DF_1E71);
        chk("single_m1_untouched", m1_readdata, 32'h0);

        // Simultaneous first requests after reset: m0 then m1
        mem[0] = 32'hA5A5_0001;
        do_reset();
        fork
            master_txn(0, 1'b1);
            master_txn(1, 1'b0);
        join
        idle(2);
        chk("tie_m0_data", m0_readdata, 32'h56DF_1E71);
        chk("tie_m1_data", m1_readdata, 32'hA5A5_0001);

        // Abort: m1 drops read during its BUSY cycle, next tie still to m1
        master_txn(0, 1'b0);
        idle(1);
        rd[1] = 1'b1;
        ad[1] = 1'b1;
        @(posedge clock); #1;
        rd[1] = 1'b0;
        idle(2);
        fork
            master_txn(0, 1'b0);
            master_txn(1, 1'b1);
        join
        idle(3);

        // Continuous contention for 20 cycles, addresses changing freely
        rdv_cnt[0] = 0;
        rdv_cnt[1] = 0;
        for (int i = 0; i < 20; i++) begin
            rd = 2'b11;
            ad = 2'($urandom);
            @(posedge clock); #1;
        end
        rd = 2'b00;
        idle(3);
`ifdef SYSID_ARB_FIXED_PRIO_EN
        chk("contend_m0_count", 32'(rdv_cnt[0]), 32'd10);
        chk("contend_m1_count", 32'(rdv_cnt[1]), 32'd0);
`else
        chk("contend_m0_count", 32'(rdv_cnt[0]), 32'd5);
        chk("contend_m1_count", 32'(rdv_cnt[1]), 32'd5);
`endif

        // Randomised traffic with new slave contents
        mem[0] = $urandom;
        mem[1] = $urandom;
        fork
            for (int i = 0; i < 15; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clock);
                master_txn(0, 1'($urandom));
            end
            for (int i = 0; i < 15; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clock);
                master_txn(1, 1'($urandom));
            end
        join
        idle(3);

        // Reset asserted in the BUSY cycle drops the pending return
        mem[1] = 32'hC0DE_0042;
        @(posedge clock); #1;
        rd[0] = 1'b1;
        ad[0] = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (wr_v[0] && n < 12);
        chk("midrst_accept_bound", {31'd0, wr_v[0]}, 32'd0);
        #1;
        reset_n = 1'b0;
        rd      = 2'b00;
        repeat (2) @(negedge clock);
        #1 reset_n = 1'b1;

        // Normal service after release
        master_txn(0, 1'b1);
        idle(3);
        chk("post_reset_data", m0_readdata, 32'hC0DE_0042);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/sysid_read_arbiter.md
# sysid_read_arbiter

Two-master read arbiter that shares the single-cycle, combinational system-ID slave (32-bit, 1-bit address: 0 → ID word, 1 → build timestamp) between two Avalon-MM read masters, e.g. the Nios II data master and a JTAG/debug master. It serialises accesses with a grant FSM. It registers the slave's combinational readdata and returns it with a `readdatavalid` pulse, so neither master ever sees the slave's combinational path.

## Interface
- `DATA_W`, 32: read data width; must match the sysid slave.
- `ADDR_W`, 1: word address width forwarded to the slave.
- `clock`  in  1: single clock for all logic.
- `reset_n`  in  1: asynchronous assert, active-low reset.
- `m0_read`  in  1: master 0 read request, held until accepted.
- `m0_address`  in  ADDR_W: master 0 word address.
- `m0_waitrequest`  out  1: low for exactly the acceptance cycle of master 0.
- `m0_readdatavalid`  out  1: one-cycle data-return strobe for master 0.
- `m0_readdata`  out  DATA_W: master 0 return data.
- `m1_read`, `m1_address`, `m1_waitrequest`, `m1_readdatavalid`, `m1_readdata`: same as master 0, for master 1.
- `s_read`  out  1: read strobe to the sysid slave.
- `s_address`  out  ADDR_W: address to the sysid slave.
- `s_readdata`  in  DATA_W: combinational data from the sysid slave.

## Operation
- FSM states:
  - IDLE: no grant.
  - BUSY: `owner` register selects the master.
- IDLE:
  - If any `mX_read` is high, pick a winner, load `owner`, and go to BUSY.
  - Otherwise stay in IDLE.
- Winner selection:
  - Single requester wins.
  - If both request, the master that was not served last wins (round-robin pointer `last`).
- BUSY:
  - `s_read`=1 and `s_address`=`owner`'s address.
  - The owner's `waitrequest`=0, so the transaction is accepted this cycle.
  - `s_readdata` is captured into the owner's readdata register.
  - `last` is set to `owner`.
  - Next state is always IDLE.
- Return: in the cycle after BUSY, the owner's `readdatavalid`=1 for exactly one cycle.
- Readdata registers: each master's readdata holds its last returned value. The other master's readdata is unchanged.
- Non-owner `waitrequest` is always 1. Outside BUSY, both `waitrequest` outputs are 1.
- Abort: if the owner's `mX_read` is low during BUSY (protocol violation), there is no capture, no `readdatavalid`, `last` is unchanged, and the FSM goes to IDLE.
- Addresses are sampled only in BUSY. Changes while waiting are tolerated.
- Reset values:
  - state=IDLE, `last`=1 (so m0 wins the first tie).
  - All `waitrequest`=1, all `readdatavalid`=0, all readdata=0.
  - `s_read`=0, `s_address`=0.
- Reset asserted mid-transaction forces all reset values immediately. A pending `readdatavalid` is dropped.

## Timing
- Request sampled in IDLE at edge N. Accept (waitrequest low) occurs in cycle N+1. Data is valid in cycle N+2.
- Data-return latency: 1 cycle after acceptance, fixed.
- Throughput: one read per 2 cycles. A new grant may be decided in the same IDLE cycle that returns the previous data.
- Back-to-back with both masters requesting continuously:
  - Grants alternate m0, m1, m0…
  - Each master completes one read per 4 cycles.
- `s_address` and `s_read` are registered-state decodes. There is no combinational path from `mX_read` to `s_*` or to `waitrequest`.

## Configuration
- `SYSID_ARB_FIXED_PRIO_EN` defined:
  - Master 0 always wins a tie, and the `last` pointer is not built.
  - Master 1 can starve under continuous m0 requests.
- Not defined: round-robin as described above.

## Structure
- Package `sysid_arb_pkg`:
  - state enum (`ST_IDLE`, `ST_BUSY`)
  - `SYSID_DATA_W`=32
  - owner encoding constants (`OWN_M0`=0, `OWN_M1`=1)
- Sub-module `sysid_rr_picker`:
  - Pure combinational 2-way picker.
  - Inputs: `req[1:0]` and `last`.
  - Output: `winner`.
  - Honours `SYSID_ARB_FIXED_PRIO_EN`.

## Test plan
- Reset: hold `reset_n`=0 → both waitrequest=1, readdatavalid=0, readdata=0. Release it with no requests → outputs unchanged.
- Single read: m0 reads addr 0 with slave returning 32'h0, then addr 1 with slave returning 32'h56DF_1E71 → waitrequest low in cycle N+1, `m0_readdatavalid` in N+2 with 32'h0, then 32'h56DF_1E71. `m1_readdata` stays 0.
- Simultaneous first requests: m0 addr 1 and m1 addr 0 raised in the same cycle → m0 served first (N+1/N+2), then m1 (N+3/N+4). Each returns the data for its own address.
- Continuous contention: both masters requesting for 20 cycles → grants strictly alternate, 5 returns each. With `SYSID_ARB_FIXED_PRIO_EN`, m0 gets all 10 and m1 gets 0.
- Abort: m1 drops read during its BUSY cycle → no `m1_readdatavalid`. The next tie still goes to m1.
- Mid-transaction reset: assert `reset_n` in the BUSY cycle → the following cycle has readdatavalid=0 for both and readdata=0. The next request after release is served normally.
